// File: rtl/norm_shift_seq.sv
// Iterative pre-rounding normalizer.
// Left-shifts an unnormalized significand STEP bits (or 1 bit) per cycle until the
// hidden bit lands at position FW-2, or right-shifts once with sticky on integer
// overflow. Produces the adjusted exponent, shift count and TINY/OVF1 flags.
// Optional build macro NORM_SHIFT_CNT_EN adds a saturating SHIFT-cycle counter port.
module norm_shift_seq #(
  parameter int unsigned STEP = 4,
  parameter int unsigned EW   = 13,
  parameter int unsigned FW   = 57
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] fr,
  input  logic [EW-1:0] er,
  input  logic          db,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] fn,
  output logic [EW-1:0] en,
  output logic [5:0]    lz,
  output logic          out_zero,
  output logic          TINY,
  output logic          OVF1
`ifdef NORM_SHIFT_CNT_EN
  ,
  output logic [15:0]   shift_cycles
`endif
);

  localparam int          EminD  = -1022;
  localparam int          EmaxD  = 1023;
  localparam int          EminS  = -126;
  localparam int          EmaxS  = 127;
  localparam int unsigned HidPos = FW - 2;
  localparam logic [5:0]  LzMax  = 6'd55;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fr_q, fr_d;
  logic [EW-1:0] er_q, er_d;
  logic          db_q, db_d;
  logic [5:0]    lz_cnt_q, lz_cnt_d;
  logic [FW-1:0] fn_q, fn_d;
  logic [EW-1:0] en_q, en_d;
  logic [5:0]    lz_q, lz_d;
  logic          zero_q, zero_d;
  logic          tiny_q, tiny_d;
  logic          ovf_q, ovf_d;
  // Result registers settle one cycle before out_valid is raised.
  logic          valid_q, valid_d;

  logic [5:0]    lz_sat;
  int            en_s;
  int            emin, emax;

  // Saturated shift count and signed view of the next exponent for flag compare.
  always_comb begin
    lz_sat = (lz_cnt_q > LzMax) ? LzMax : lz_cnt_q;
    en_s   = int'($signed(en_d));
    emin   = db_q ? EminD : EminS;
    emax   = db_q ? EmaxD : EmaxS;
  end

  // Next-state logic: accept, iterative shift, result hold and handshake.
  always_comb begin
    state_d  = state_q;
    fr_d     = fr_q;
    er_d     = er_q;
    db_d     = db_q;
    lz_cnt_d = lz_cnt_q;
    fn_d     = fn_q;
    en_d     = en_q;
    lz_d     = lz_q;
    zero_d   = zero_q;
    tiny_d   = tiny_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (in_valid) begin
          fr_d     = fr;
          er_d     = er;
          db_d     = db;
          lz_cnt_d = '0;
          state_d  = StShift;
        end
      end

      StShift: begin
        if (fr_q == '0) begin
          fn_d    = '0;
          en_d    = er_q;
          lz_d    = '0;
          zero_d  = 1'b1;
          state_d = StDone;
        end else if (fr_q[FW-1]) begin
          // Integer overflow: one right shift, shifted-out bit folded into sticky.
          fn_d    = {1'b0, fr_q[FW-1:2], fr_q[1] | fr_q[0]};
          en_d    = er_q + EW'(1);
          lz_d    = '0;
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (fr_q[HidPos]) begin
          fn_d    = fr_q;
          en_d    = er_q - EW'(lz_sat);
          lz_d    = lz_sat;
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (fr_q[HidPos -: STEP] == '0) begin
          fr_d     = fr_q << STEP;
          lz_cnt_d = lz_cnt_q + 6'(STEP);
        end else begin
          fr_d     = fr_q << 1;
          lz_cnt_d = lz_cnt_q + 6'd1;
        end

        if (state_d == StDone) begin
          tiny_d = !zero_d && (en_s < emin);
          ovf_d  = !zero_d && (en_s > emax);
        end
      end

      StDone: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      fr_q     <= '0;
      er_q     <= '0;
      db_q     <= 1'b0;
      lz_cnt_q <= '0;
      fn_q     <= '0;
      en_q     <= '0;
      lz_q     <= '0;
      zero_q   <= 1'b0;
      tiny_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fr_q     <= fr_d;
      er_q     <= er_d;
      db_q     <= db_d;
      lz_cnt_q <= lz_cnt_d;
      fn_q     <= fn_d;
      en_q     <= en_d;
      lz_q     <= lz_d;
      zero_q   <= zero_d;
      tiny_q   <= tiny_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef NORM_SHIFT_CNT_EN
  logic [15:0] cyc_q;

  // Saturating count of cycles spent in SHIFT since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (state_q == StShift && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign shift_cycles = cyc_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = valid_q;
  assign fn        = fn_q;
  assign en        = en_q;
  assign lz        = lz_q;
  assign out_zero  = zero_q;
  assign TINY      = tiny_q;
  assign OVF1      = ovf_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Self-checking bench for norm_shift_seq: directed corner vectors plus random
// operands compared against a behavioural reference model.
module tb_norm_shift_seq;

  localparam int unsigned STEP = 4;
  localparam int unsigned EW   = 13;
  localparam int unsigned FW   = 57;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] fr;
  logic [EW-1:0] er;
  logic          db;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] fn;
  logic [EW-1:0] en;
  logic [5:0]    lz;
  logic          out_zero;
  logic          TINY;
  logic          OVF1;
`ifdef NORM_SHIFT_CNT_EN
  logic [15:0]   shift_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  norm_shift_seq #(
    .STEP(STEP),
    .EW  (EW),
    .FW  (FW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fr       (fr),
    .er       (er),
    .db       (db),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fn       (fn),
    .en       (en),
    .lz       (lz),
    .out_zero (out_zero),
    .TINY     (TINY),
    .OVF1     (OVF1)
`ifdef NORM_SHIFT_CNT_EN
    ,
    .shift_cycles(shift_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: value-level description of the normalizer.
  task automatic model(input logic [63:0] f, input logic [EW-1:0] e, input logic d,
                       output logic [63:0] xfn, output logic [EW-1:0] xen,
                       output int xlz, output bit xzero, output bit xtiny,
                       output bit xovf, output int xlat);
    int msb;
    int se;
    xzero = 0;
    xlz   = 0;
    xlat  = 2;
    if (f == 0) begin
      xzero = 1;
      xfn   = 0;
      xen   = e;
    end else if (f >= (64'd1 << 56)) begin
      xfn = (f >> 1) | (f & 64'd1);
      xen = e + EW'(1);
    end else begin
      msb = 0;
      for (int i = 0; i < 56; i++) if (f[i]) msb = i;
      xlz  = 55 - msb;
      xfn  = f << xlz;
      xen  = e - EW'(xlz);
      xlat = 2 + xlz / STEP + xlz % STEP;
    end
    se    = (xen >= EW'(4096)) ? int'(xen) - 8192 : int'(xen);
    xtiny = !xzero && (se < (d ? -1022 : -126));
    xovf  = !xzero && (se > (d ? 1023 : 127));
  endtask

  task automatic run_op(input string tag, input logic [63:0] f, input logic [EW-1:0] e,
                        input logic d, input bit hold);
    logic [63:0]   xfn;
    logic [EW-1:0] xen;
    int            xlz, xlat, cyc;
    bit            xzero, xtiny, xovf;
    logic [FW-1:0] fn_s;
    logic [EW-1:0] en_s;
    model(f, e, d, xfn, xen, xlz, xzero, xtiny, xovf, xlat);
    @(negedge clk);
    fr        = f[FW-1:0];
    er        = e;
    db        = d;
    in_valid  = 1'b1;
    out_ready = !hold;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(xlat));
    check({tag, " fn"}, 64'(fn), xfn);
    check({tag, " en"}, 64'(en), 64'(xen));
    check({tag, " lz"}, 64'(lz), 64'(xlz));
    check({tag, " zero"}, 64'(out_zero), 64'(xzero));
    check({tag, " tiny"}, 64'(TINY), 64'(xtiny));
    check({tag, " ovf"}, 64'(OVF1), 64'(xovf));
    if (hold) begin
      fn_s = fn;
      en_s = en;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        check({tag, " hold valid"}, 64'(out_valid), 64'd1);
        check({tag, " hold ready"}, 64'(in_ready), 64'd0);
        check({tag, " hold fn"}, 64'(fn), 64'(fn_s));
        check({tag, " hold en"}, 64'(en), 64'(en_s));
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " drain valid"}, 64'(out_valid), 64'd0);
    check({tag, " drain ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rf;
    int          p;
    bit          rv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fr        = '0;
    er        = '0;
    db        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset fn", 64'(fn), 64'd0);
    check("reset en", 64'(en), 64'd0);
    check("reset lz", 64'(lz), 64'd0);
    check("reset valid", 64'(out_valid), 64'd0);
    check("reset ready", 64'(in_ready), 64'd1);
    check("reset flags", 64'({out_zero, TINY, OVF1}), 64'd0);

    run_op("norm", 64'd1 << 55, 13'd0, 1'b1, 0);
    run_op("lz9", 64'd1 << 46, 13'd100, 1'b0, 0);
    run_op("rshift", (64'd1 << 56) | 64'd1, 13'd127, 1'b0, 0);
    run_op("tiny_s", 64'd1 << 50, 13'h1F86, 1'b0, 0);
    run_op("tiny_d", 64'd1 << 50, 13'h1F86, 1'b1, 0);
    run_op("zero", 64'd0, 13'h0055, 1'b0, 0);
    run_op("lz55", 64'd1, 13'd10, 1'b1, 1);

    // Reset while shifting discards the operand.
    @(negedge clk);
    fr       = 57'd1;
    er       = 13'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst ready", 64'(in_ready), 64'd1);
    check("midrst valid", 64'(out_valid), 64'd0);
    rv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) rv = 1;
    end
    check("midrst no result", 64'(rv), 64'd0);

    for (int k = 0; k < 60; k++) begin
      p  = $urandom_range(0, 57);
      rf = {32'($urandom), 32'($urandom)};
      if (p == 57) rf = 0;
      else rf = (rf & ((64'd1 << p) - 64'd1)) | (64'd1 << p);
      run_op($sformatf("rnd%0d", k), rf, EW'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
